// File: rtl/vedic_mul_sched_if.sv
// Request/response bundle between the client datapaths and vedic_mul_sched.
// Operand lanes are packed per requester: requester i owns bits [i*W +: W].
interface vedic_mul_sched_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 32,
  parameter int unsigned IDW  = $clog2(NREQ)
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [2*W-1:0]    rsp_data;
  logic [IDW-1:0]    rsp_id;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );
endinterface

// File: rtl/vedic_mul_sched.sv
// Round-robin scheduler sharing one combinational Vedic 32x32 multiplier
// between NREQ requesters; one operation every three cycles without stalls.

// 2x2 Urdhva-Tiryagbhyam cell built from AND gates and two half adders.
module vedic_2x2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] out
);
  logic w_p0;
  logic w_x;
  logic w_y;
  logic w_hh;
  logic w_c1;

  assign w_p0 = a[0] & b[0];
  assign w_x  = a[1] & b[0];
  assign w_y  = a[0] & b[1];
  assign w_hh = a[1] & b[1];
  assign w_c1 = w_x & w_y;
  assign out  = {w_hh & w_c1, w_hh ^ w_c1, w_x ^ w_y, w_p0};
endmodule

// Recombines four half-width partial products: lo + (cross terms << H) + (hi << 2H).
module vedic_merge #(
  parameter int unsigned H = 2
) (
  input  logic [2*H-1:0] q0,
  input  logic [2*H-1:0] q1,
  input  logic [2*H-1:0] q2,
  input  logic [2*H-1:0] q3,
  output logic [4*H-1:0] out
);
  localparam int unsigned PW = 4 * H;

  logic [PW-1:0] w_lo;
  logic [PW-1:0] w_mid;
  logic [PW-1:0] w_hi;

  assign w_lo  = PW'(q0);
  assign w_mid = (PW'(q1) + PW'(q2)) << H;
  assign w_hi  = {q3, (2*H)'(0)};
  assign out   = w_lo + w_mid + w_hi;
endmodule

module vedic_4x4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] out
);
  logic [3:0] w_q0;
  logic [3:0] w_q1;
  logic [3:0] w_q2;
  logic [3:0] w_q3;

  vedic_2x2 u_q0 (.a(a[1:0]), .b(b[1:0]), .out(w_q0));
  vedic_2x2 u_q1 (.a(a[3:2]), .b(b[1:0]), .out(w_q1));
  vedic_2x2 u_q2 (.a(a[1:0]), .b(b[3:2]), .out(w_q2));
  vedic_2x2 u_q3 (.a(a[3:2]), .b(b[3:2]), .out(w_q3));
  vedic_merge #(.H(2)) u_merge (.q0(w_q0), .q1(w_q1), .q2(w_q2), .q3(w_q3), .out(out));
endmodule

module vedic_8x8 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] out
);
  logic [7:0] w_q0;
  logic [7:0] w_q1;
  logic [7:0] w_q2;
  logic [7:0] w_q3;

  vedic_4x4 u_q0 (.a(a[3:0]), .b(b[3:0]), .out(w_q0));
  vedic_4x4 u_q1 (.a(a[7:4]), .b(b[3:0]), .out(w_q1));
  vedic_4x4 u_q2 (.a(a[3:0]), .b(b[7:4]), .out(w_q2));
  vedic_4x4 u_q3 (.a(a[7:4]), .b(b[7:4]), .out(w_q3));
  vedic_merge #(.H(4)) u_merge (.q0(w_q0), .q1(w_q1), .q2(w_q2), .q3(w_q3), .out(out));
endmodule

module vedic_16x16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] out
);
  logic [15:0] w_q0;
  logic [15:0] w_q1;
  logic [15:0] w_q2;
  logic [15:0] w_q3;

  vedic_8x8 u_q0 (.a(a[7:0]),  .b(b[7:0]),  .out(w_q0));
  vedic_8x8 u_q1 (.a(a[15:8]), .b(b[7:0]),  .out(w_q1));
  vedic_8x8 u_q2 (.a(a[7:0]),  .b(b[15:8]), .out(w_q2));
  vedic_8x8 u_q3 (.a(a[15:8]), .b(b[15:8]), .out(w_q3));
  vedic_merge #(.H(8)) u_merge (.q0(w_q0), .q1(w_q1), .q2(w_q2), .q3(w_q3), .out(out));
endmodule

module vedic_32x32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] out
);
  logic [31:0] w_q0;
  logic [31:0] w_q1;
  logic [31:0] w_q2;
  logic [31:0] w_q3;

  vedic_16x16 u_q0 (.a(a[15:0]),  .b(b[15:0]),  .out(w_q0));
  vedic_16x16 u_q1 (.a(a[31:16]), .b(b[15:0]),  .out(w_q1));
  vedic_16x16 u_q2 (.a(a[15:0]),  .b(b[31:16]), .out(w_q2));
  vedic_16x16 u_q3 (.a(a[31:16]), .b(b[31:16]), .out(w_q3));
  vedic_merge #(.H(16)) u_merge (.q0(w_q0), .q1(w_q1), .q2(w_q2), .q3(w_q3), .out(out));
endmodule

module vedic_mul_sched #(
  parameter int unsigned NREQ = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  vedic_mul_sched_if.slave  bus,
  output logic              busy,
  output logic [15:0]       done_cnt
);
  localparam int unsigned W   = 32;
  localparam int unsigned PW  = 2 * W;
  localparam int unsigned IDW = $clog2(NREQ);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e          r_state;
  logic [W-1:0]    r_op_a;
  logic [W-1:0]    r_op_b;
  logic [IDW-1:0]  r_id;
  logic [IDW-1:0]  r_last;
  logic            r_rsp_valid;
  logic [PW-1:0]   r_rsp_data;
  logic [IDW-1:0]  r_rsp_id;
  logic            r_busy;
  logic [15:0]     r_done_cnt;

  logic            w_gnt_vld;
  logic [IDW-1:0]  w_gnt;
  logic [IDW-1:0]  w_idx;
  logic            w_accept;
  logic [W-1:0]    w_sel_a;
  logic [W-1:0]    w_sel_b;
  logic [PW-1:0]   w_prod;

  // Round-robin search: first valid index strictly after the last winner.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    w_idx     = '0;
    for (int k = 1; k <= int'(NREQ); k++) begin
      w_idx = IDW'((int'(r_last) + k) % int'(NREQ));
      if (!w_gnt_vld && bus.req_valid[w_idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = w_idx;
      end
    end
  end

  // Grant is offered only from IDLE, so accept never overlaps a response.
  assign w_accept = rst_n && (r_state == S_IDLE) && w_gnt_vld;

  always_comb begin
    bus.req_ready = '0;
    if (w_accept) begin
      bus.req_ready[w_gnt] = 1'b1;
    end
  end

  assign w_sel_a = bus.req_a[32'(w_gnt) * W +: W];
  assign w_sel_b = bus.req_b[32'(w_gnt) * W +: W];

  vedic_32x32 u_mul (
    .a   (r_op_a),
    .b   (r_op_b),
    .out (w_prod)
  );

  // Scheduler FSM: IDLE -> MUL -> RESP -> IDLE, all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_id        <= '0;
      r_last      <= IDW'(NREQ - 1);
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_id    <= '0;
      r_busy      <= 1'b0;
      r_done_cnt  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op_a  <= w_sel_a;
            r_op_b  <= w_sel_b;
            r_id    <= w_gnt;
            r_last  <= w_gnt;
            r_busy  <= 1'b1;
            r_state <= S_MUL;
          end
        end
        S_MUL: begin
          r_rsp_data  <= w_prod;
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_done_cnt  <= r_done_cnt + 16'd1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_id    = r_rsp_id;
  assign busy          = r_busy;
  assign done_cnt      = r_done_cnt;
endmodule

// File: tb/tb_vedic_mul_sched.sv
// Bench for vedic_mul_sched: directed scenarios plus a random soak, all checked
// against a transaction-level model of arbitration, latency and products.
module tb_vedic_mul_sched;
  localparam int unsigned NREQ = 4;
  localparam int unsigned W    = 32;
  localparam int unsigned IDW  = 2;
  localparam int unsigned AW   = NREQ * W;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        busy;
  logic [15:0] done_cnt;

  vedic_mul_sched_if #(.NREQ(NREQ), .W(W)) bus ();

  vedic_mul_sched #(.NREQ(NREQ)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .busy     (busy),
    .done_cnt (done_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: 0 = waiting for accept, 1 = product in flight, 2 = response pending
  int          m_phase = 0;
  int          m_last  = NREQ - 1;
  logic [15:0] m_done  = '0;
  logic [63:0] m_data  = '0;
  int          m_id    = 0;
  int          acc_g   = -1;
  int          cyc     = 0;
  int          n_acc   = 0;
  int          n_rsp   = 0;
  bit          hold_valid = 1'b0;
  int          grants[$];
  int          acc_cyc[$];
  logic [W-1:0] a_arr [NREQ];
  logic [W-1:0] b_arr [NREQ];

  task automatic pack_ops();
    logic [AW-1:0] pa;
    logic [AW-1:0] pb;
    pa = '0;
    pb = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      pa = (pa << W) | AW'(a_arr[i]);
      pb = (pb << W) | AW'(b_arr[i]);
    end
    bus.req_a = pa;
    bus.req_b = pb;
  endtask

  function automatic logic [W-1:0] rnd_op();
    case ($urandom % 8)
      0:       return '0;
      1:       return '1;
      default: return W'($urandom);
    endcase
  endfunction

  // One cycle: called at a falling edge with inputs settled; checks, then advances model.
  task automatic tick();
    logic [NREQ-1:0] exp_rdy;
    int g;
    #2;
    acc_g = -1;
    if (!rst_n) begin
      chk("rst_req_ready", 64'(bus.req_ready), 64'(0));
      chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
      chk("rst_rsp_data",  bus.rsp_data,       64'(0));
      chk("rst_rsp_id",    64'(bus.rsp_id),    64'(0));
      chk("rst_busy",      64'(busy),          64'(0));
      chk("rst_done_cnt",  64'(done_cnt),      64'(0));
      m_phase = 0;
      m_last  = NREQ - 1;
      m_done  = '0;
    end else begin
      exp_rdy = '0;
      g = -1;
      if (m_phase == 0) begin
        for (int k = 1; k <= int'(NREQ); k++) begin
          int idx;
          idx = (m_last + k) % NREQ;
          if (g < 0 && bus.req_valid[IDW'(idx)]) g = idx;
        end
      end
      if (g >= 0) exp_rdy[IDW'(g)] = 1'b1;
      chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
      chk("rsp_valid", 64'(bus.rsp_valid), 64'(m_phase == 2));
      chk("busy",      64'(busy),          64'(m_phase != 0));
      chk("done_cnt",  64'(done_cnt),      64'(m_done));
      if (m_phase == 2) begin
        chk("rsp_data", bus.rsp_data,    m_data);
        chk("rsp_id",   64'(bus.rsp_id), 64'(m_id));
      end
      if (g >= 0) begin
        m_data  = 64'(W'(bus.req_a >> (g * W))) * 64'(W'(bus.req_b >> (g * W)));
        m_id    = g;
        m_last  = g;
        m_phase = 1;
        acc_g   = g;
        grants.push_back(g);
        acc_cyc.push_back(cyc);
        n_acc++;
      end else if (m_phase == 1) begin
        m_phase = 2;
      end else if (m_phase == 2 && bus.rsp_ready) begin
        m_phase = 0;
        m_done  = m_done + 16'd1;
        n_rsp++;
      end
    end
    @(negedge clk);
    cyc++;
    if (acc_g >= 0 && !hold_valid) bus.req_valid[IDW'(acc_g)] = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int exp_order[6];
    int d_start;
    int r_start;
    int a_start;
    int issued;
    int budget;

    exp_order = '{0, 1, 2, 3, 0, 1};
    for (int i = 0; i < int'(NREQ); i++) begin
      a_arr[i] = '0;
      b_arr[i] = '0;
    end
    pack_ops();
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Single request from requester 2
    a_arr[2] = 32'h3;
    b_arr[2] = 32'h5;
    pack_ops();
    bus.req_valid = 4'b0100;
    #1;
    chk("single_ready", 64'(bus.req_ready), 64'(4'b0100));
    tick();
    tick();
    #1;
    chk("single_rsp_valid", 64'(bus.rsp_valid), 64'(1));
    chk("single_rsp_data",  bus.rsp_data,       64'hF);
    chk("single_rsp_id",    64'(bus.rsp_id),    64'(2));
    tick();
    tick();
    chk("single_done_cnt", 64'(done_cnt), 64'(1));

    // Fairness: everyone valid, no backpressure
    do_reset();
    for (int i = 0; i < int'(NREQ); i++) begin
      a_arr[i] = rnd_op();
      b_arr[i] = rnd_op();
    end
    pack_ops();
    grants.delete();
    acc_cyc.delete();
    hold_valid = 1'b1;
    bus.req_valid = '1;
    bus.rsp_ready = 1'b1;
    run(18);
    hold_valid = 1'b0;
    bus.req_valid = '0;
    run(4);
    chk("fair_grant_cnt", 64'(grants.size()), 64'(6));
    for (int i = 0; i < 6 && i < grants.size(); i++)
      chk($sformatf("fair_grant%0d", i), 64'(grants[i]), 64'(exp_order[i]));
    for (int i = 1; i < 6 && i < acc_cyc.size(); i++)
      chk($sformatf("fair_spacing%0d", i), 64'(acc_cyc[i] - acc_cyc[i-1]), 64'(3));

    // Backpressure: all-ones operands, response stalled for five cycles
    a_arr[0] = '1;
    b_arr[0] = '1;
    pack_ops();
    bus.req_valid = 4'b0001;
    bus.rsp_ready = 1'b0;
    tick();
    bus.req_valid = 4'b0010;
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_rsp_data",  bus.rsp_data,        64'hFFFFFFFE00000001);
      chk("bp_req_ready", 64'(bus.req_ready),  64'(0));
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    run(5);

    // Reset during MUL after accepting requester 1
    bus.req_valid = 4'b0010;
    a_arr[1] = rnd_op();
    b_arr[1] = rnd_op();
    pack_ops();
    while (m_phase != 0) tick();
    tick();
    chk("rst_mid_in_mul", 64'(m_phase), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy",      64'(busy),          64'(0));
    chk("rst_mid_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    tick();
    rst_n = 1'b1;
    bus.req_valid = 4'b1010;
    #1;
    chk("rst_mid_first_grant", 64'(bus.req_ready), 64'(4'b0010));
    tick();
    run(8);

    // Random soak with random response backpressure
    hold_valid = 1'b0;
    bus.req_valid = '0;
    d_start = int'(m_done);
    r_start = n_rsp;
    a_start = n_acc;
    issued = 0;
    budget = 0;
    while ((n_rsp - r_start) < 200 && budget < 6000) begin
      for (int i = 0; i < int'(NREQ); i++) begin
        if (!bus.req_valid[IDW'(i)] && issued < 200 && ($urandom % 3) == 0) begin
          a_arr[i] = rnd_op();
          b_arr[i] = rnd_op();
          pack_ops();
          bus.req_valid[IDW'(i)] = 1'b1;
          issued++;
        end
      end
      bus.rsp_ready = ($urandom % 4) != 0;
      tick();
      budget++;
    end
    bus.rsp_ready = 1'b1;
    run(4);
    chk("soak_rsp_cnt",    64'(n_rsp - r_start), 64'(200));
    chk("soak_acc_eq_rsp", 64'(n_acc - a_start), 64'(n_rsp - r_start));
    chk("soak_done_cnt",   64'(done_cnt),        64'(16'(d_start + 200)));

    // Counter wrap from 16'hFFFF
    bus.req_valid = '0;
    run(2);
    force dut.r_done_cnt = 16'hFFFF;
    #1;
    release dut.r_done_cnt;
    m_done = 16'hFFFF;
    tick();
    a_arr[3] = rnd_op();
    b_arr[3] = rnd_op();
    pack_ops();
    bus.req_valid = 4'b1000;
    bus.rsp_ready = 1'b1;
    run(4);
    chk("cnt_wrap", 64'(done_cnt), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/vedic_mul_sched.md
# vedic_mul_sched

Round-robin scheduler that shares one combinational `vedic_32x32` multiplier between `NREQ` requesters. Each requester presents a 32x32 operand pair on a valid/ready port. The scheduler grants one request at a time and registers the operands into the shared multiplier. It captures the 64-bit product and returns it on a single response port, tagged with the requester ID. It sits between the client datapaths and the multiplier instance, which it owns internally.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `W`, 32: operand width, fixed to the `vedic_32x32` width.
- `IDW`, `$clog2(NREQ)`: requester-ID width (derived).

- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_ready`  out  NREQ  per-requester accept; at most one bit high.
- `req_a`  in  NREQ*W  operand A; requester i uses bits [i*W +: W].
- `req_b`  in  NREQ*W  operand B; same packing as `req_a`.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response consumer ready.
- `rsp_data`  out  2W  product a*b, unsigned.
- `rsp_id`  out  IDW  index of the requester that owns `rsp_data`.
- `busy`  out  1  high in MUL and RESP states.
- `done_cnt`  out  16  count of completed responses; wraps at 16'hFFFF -> 0.

## Operation
- **State machine:** IDLE -> MUL -> RESP -> IDLE.
- **IDLE:**
  - If any `req_valid` is set, the arbiter picks the winner g.
  - Search starts at `last+1` (mod NREQ) and takes the first index with `req_valid` set.
  - `req_ready[g]` is driven high combinationally; all other bits stay 0.
  - On the clock edge where `req_valid[g] & req_ready[g]`:
    - latch `req_a[g]` and `req_b[g]` into `op_a` and `op_b`;
    - latch g into `id_q`;
    - set `last` to g;
    - go to MUL.
- **MUL:**
  - `op_a` and `op_b` drive the `vedic_32x32` instance.
  - At the next edge, latch its `out` into `rsp_data` and `id_q` into `rsp_id`, set `rsp_valid`, and go to RESP.
- **RESP:**
  - Hold `rsp_valid`, `rsp_data` and `rsp_id` stable until `rsp_ready` is high.
  - On that edge: clear `rsp_valid`, increment `done_cnt`, go to IDLE.
- **Ready gating:** `req_ready` is all-zero in MUL and in RESP. There is no overlap of accept with response.
- **Arbitration pointer:** `last` changes only on an accepted handshake. A requester that drops `req_valid` before it is accepted loses nothing and the pointer does not move.
- **Requester obligations:** a requester must hold `req_valid`, `req_a` and `req_b` stable until accepted. If it changes them earlier, the scheduler simply samples whatever is present on the accept edge.
- **Arithmetic:** unsigned, full 2W-bit product, no truncation or rounding.

## Timing
- **Reset:** `rst_n` low asynchronously forces:
  - state to IDLE;
  - `rsp_valid` = 0, `rsp_data` = 0, `rsp_id` = 0;
  - `done_cnt` = 0;
  - `op_a` = `op_b` = 0;
  - `last` = NREQ-1, so requester 0 has first priority;
  - `req_ready` = 0 while `rst_n` is low.
- **Reset mid-operation:** an in-flight transaction is discarded, with no response and no `done_cnt` increment. The first grant after reset goes to the lowest-index valid requester.
- **Latency:** accept edge T -> `rsp_valid` high after edge T+1. Earliest `rsp_ready` handshake is at edge T+2; earliest next accept is at edge T+3.
- **Throughput:** one operation per 3 cycles with no backpressure.
- **Stall:** each cycle `rsp_ready` is low extends RESP by one cycle.
- **Combinational paths:**
  - `req_ready` depends combinationally on `req_valid` and on registered state and `last`.
  - There is no combinational path from `rsp_ready` to `req_ready`.
- **Multiplier settling:** the multiplier must settle within one clock period from the `op_a`/`op_b` registers to `rsp_data`.

## Test plan
- **Single request:** requester 2 sets a=32'h3, b=32'h5 with the other requesters idle -> `req_ready`=4'b0100 in the same cycle. `rsp_valid` rises one cycle after accept, with `rsp_data`=64'hF and `rsp_id`=2. `done_cnt`=1 after the `rsp_ready` handshake.
- **Fairness and wrap:** all 4 requesters held valid continuously with `rsp_ready`=1 -> grant order 0,1,2,3,0,1. Accepts are exactly 3 cycles apart and `req_ready` is never multi-hot.
- **Backpressure:** `rsp_ready` low for 5 cycles with a=32'hFFFFFFFF, b=32'hFFFFFFFF -> `rsp_data`=64'hFFFFFFFE00000001, held stable throughout. `req_ready`=0 throughout the stall. Completion follows on the first `rsp_ready` cycle.
- **Reset mid-operation:** assert `rst_n` low during MUL after accepting requester 1 -> all outputs read 0 immediately. After release with requesters 1 and 3 valid, requester 1 is granted first as the lowest-index valid requester. No stale response appears.
- **Random soak:** 200 random a/b pairs (`$random`) on random requesters, with random `rsp_ready` toggling -> every response matches the golden a*b and its `rsp_id`. Response count equals accept count and equals `done_cnt`.
- **Counter wrap:** preload or run until `done_cnt`=16'hFFFF, then complete one more operation -> `done_cnt`=0.
